// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one command byte plus odd parity on device clock falls and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES     = 50,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_FIRST,
        SHIFT,
        WAIT_RELEASE,
        FAIL
    } state_t;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] RTS_LAST     = 20'(RTS_CYCLES - 1);
    localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] XFER_LAST    = 20'(XFER_TIMEOUT - 1);
    localparam logic [19:0] CNT_MAX      = 20'hFFFFF;
    localparam logic [3:0]  ACK_INDEX    = 4'd10;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [8:0]  shreg_q, shreg_d;
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [2:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        clk_s;
    logic        data_s;
    logic        fall;
    logic [19:0] cnt_inc;

    // Pad synchronizers; the third clock flop holds the previous synced level
    // for edge detection. They reset to the idle (released) bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
        end
    end

    assign clk_s   = clk_sync[1];
    assign data_s  = data_sync[1];
    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 20'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Outputs are registered, so a failure releases the lines and raises error
    // on the same edge that enters FAIL; FAIL then lasts exactly one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (tx_start && !done_q) begin
                    shreg_d  = {~^tx_data, tx_data};
                    cnt_d    = '0;
                    idx_d    = '0;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = INHIBIT;
                end
            end

            INHIBIT: begin
                cnt_d = cnt_inc;
                if (cnt_q >= INHIBIT_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end
            end

            RTS: begin
                cnt_d = cnt_inc;
                if (cnt_q >= RTS_LAST) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = WAIT_FIRST;
                end
            end

            // The first fall restarts the counter as the transfer timer.
            WAIT_FIRST: begin
                if (fall) begin
                    cnt_d     = '0;
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b1, shreg_q[8:1]};
                    idx_d     = 4'd1;
                    state_d   = SHIFT;
                end else if (cnt_q >= START_LAST) begin
                    state_d   = FAIL;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Shifting in ones means the tenth fall drives a released stop bit.
            SHIFT: begin
                cnt_d = cnt_inc;
                if (cnt_q >= XFER_LAST) begin
                    state_d   = FAIL;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                end else if (fall) begin
                    if (idx_q == ACK_INDEX) begin
                        if (!data_s) begin
                            state_d = WAIT_RELEASE;
                        end else begin
                            state_d   = FAIL;
                            clk_oe_d  = 1'b0;
                            data_oe_d = 1'b0;
                            busy_d    = 1'b0;
                            error_d   = 1'b1;
                        end
                    end else begin
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b1, shreg_q[8:1]};
                        idx_d     = idx_q + 4'd1;
                    end
                end
            end

            WAIT_RELEASE: begin
                cnt_d = cnt_inc;
                if (cnt_q >= XFER_LAST) begin
                    state_d   = FAIL;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                end else if (clk_s && data_s) begin
                    state_d   = IDLE;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end

            FAIL: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
